multi_debounce: RTL and testbench

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 152 +++++++++++++++
 rtl/multi_debounce.sv | 59 +++++
 tb/tb_multi_debounce.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared constants for the multi-channel button debouncer: default values of
//   the block parameters and the legal range limits of each parameter.
//   Imported by debounce_channel and multi_debounce.
// -----------------------------------------------------------------------------
package debounce_pkg;

  // Range limits
  localparam int MIN_CHANNELS        = 1;
  localparam int MAX_CHANNELS        = 32;
  localparam int MIN_SYNC_STAGES     = 2;
  localparam int MAX_SYNC_STAGES     = 4;
  localparam int MIN_DEBOUNCE_CYCLES = 1;

  // Parameter defaults
  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_HOLD_CYCLES     = 0;   // 0 = long-press logic not built

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: SYNC_STAGES-deep synchroniser, debounce counter that
//   accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing samples,
//   registered rise/fall pulses and optional long-press detection.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_in     in   raw asynchronous button level
//   btn_stable out  debounced level
//   btn_rise   out  one-cycle pulse on the edge btn_stable goes 0->1
//   btn_fall   out  one-cycle pulse on the edge btn_stable goes 1->0
//   btn_hold   out  one-cycle pulse HOLD_CYCLES cycles after btn_rise
//   btn_held   out  high from btn_hold until the btn_fall edge
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_stable,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_hold,
  output logic btn_held
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so it can never wrap.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce counter and edge detection
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;            // any agreeing sample restarts the count
    if (sync_out != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_out;  // DEBOUNCE_CYCLES-th consecutive disagreement
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Pulses are registered alongside stable_q, so they appear on the very
    // edge btn_stable changes; rise and fall are mutually exclusive by design.
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign btn_stable = stable_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;

  // ---------------------------------------------------------------------------
  // Long-press detection (only built when HOLD_CYCLES > 0)
  // ---------------------------------------------------------------------------
  if (HOLD_CYCLES > 0) begin : g_hold
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_q, hold_d;
    logic              held_q, held_d;

    always_comb begin
      hold_cnt_d = hold_cnt_q;
      held_d     = held_q;

      // hold_cnt_q equals the number of edges since the btn_rise edge; parking
      // at HOLD_SAT after firing guarantees one pulse per press.
      if (!stable_q) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q != HOLD_SAT) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end

      // Gating with stable_d keeps a release on the firing edge from
      // producing a hold pulse together with btn_fall.
      hold_d = stable_q & stable_d & (hold_cnt_q == HOLD_LAST);

      if (fall_d) begin
        held_d = 1'b0;
      end else if (hold_d) begin
        held_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt_q <= '0;
        hold_q     <= 1'b0;
        held_q     <= 1'b0;
      end else begin
        hold_cnt_q <= hold_cnt_d;
        hold_q     <= hold_d;
        held_q     <= held_d;
      end
    end

    assign btn_hold = hold_q;
    assign btn_held = held_q;
  end else begin : g_no_hold
    assign btn_hold = 1'b0;
    assign btn_held = 1'b0;
  end

endmodule : debounce_channel

// File: rtl/multi_debounce.sv
// -----------------------------------------------------------------------------
// multi_debounce
//   CHANNELS fully independent button debouncers (one debounce_channel each)
//   plus a combined any_rise flag. Nothing but any_rise spans channels.
//   Legal ranges: CHANNELS 1..32, SYNC_STAGES 2..4, DEBOUNCE_CYCLES >= 1,
//   HOLD_CYCLES >= 0 (0 removes the long-press logic).
//   rst_n deassertion must be synchronised to clk outside this block.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_in     in   [CHANNELS] raw asynchronous button levels
//   btn_stable out  [CHANNELS] debounced levels
//   btn_rise   out  [CHANNELS] one-cycle pulse on stable 0->1
//   btn_fall   out  [CHANNELS] one-cycle pulse on stable 1->0
//   btn_hold   out  [CHANNELS] one-cycle long-press pulse
//   btn_held   out  [CHANNELS] level from btn_hold until release
//   any_rise   out  OR of btn_rise
// -----------------------------------------------------------------------------
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_stable,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_hold,
  output logic [CHANNELS-1:0] btn_held,
  output logic                any_rise
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_channel (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_in     (btn_in[i]),
      .btn_stable (btn_stable[i]),
      .btn_rise   (btn_rise[i]),
      .btn_fall   (btn_fall[i]),
      .btn_hold   (btn_hold[i]),
      .btn_held   (btn_held[i])
    );
  end

  // Combinational OR of already-registered pulses: no extra cycle of latency.
  assign any_rise = |btn_rise;

endmodule : multi_debounce

// File: tb/tb_multi_debounce.sv
// -----------------------------------------------------------------------------
// tb_multi_debounce
//   Directed bench for multi_debounce with CHANNELS=4, SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4, HOLD_CYCLES=10. Edge e counts rising edges after the
//   input change; outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_multi_debounce;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int LAT  = SYNC + DEB - 1;   // edges from input change to stable

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] btn_stable, btn_rise, btn_fall, btn_hold, btn_held;
  logic          any_rise;

  int n_tests = 0;
  int n_fail  = 0;

  multi_debounce #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .btn_stable (btn_stable),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .btn_hold   (btn_hold),
    .btn_held   (btn_held),
    .any_rise   (any_rise)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [CH-1:0] stable_e,
                           input logic [CH-1:0] rise_e, input logic [CH-1:0] fall_e,
                           input logic [CH-1:0] hold_e, input logic [CH-1:0] held_e);
    check({tag, " stable"}, 32'(btn_stable), 32'(stable_e));
    check({tag, " rise"},   32'(btn_rise),   32'(rise_e));
    check({tag, " fall"},   32'(btn_fall),   32'(fall_e));
    check({tag, " hold"},   32'(btn_hold),   32'(hold_e));
    check({tag, " held"},   32'(btn_held),   32'(held_e));
    check({tag, " any_rise"}, 32'(any_rise), 32'(|rise_e));
  endtask

  // Press channel ch for len cycles (input high for edges 0..len-1) and check
  // every output vector on each edge. Expected timeline (len >= DEB):
  //   rise at LAT, fall at len+LAT, hold at LAT+HOLD only if still pressed.
  task automatic run_press(input int ch, input int len);
    logic [CH-1:0] m;
    bit acc, hold_ok;
    int total;
    m       = CH'(1) << ch;
    acc     = (len >= DEB);
    hold_ok = acc && (len > HOLD);
    total   = len + LAT + 4;
    btn_in[ch] = 1'b1;
    for (int e = 0; e < total; e++) begin
      if (e == len) btn_in[ch] = 1'b0;
      tick();
      check_all($sformatf("press ch%0d len%0d e%0d", ch, len, e),
                (acc && e >= LAT && e < len + LAT)            ? m : '0,
                (acc && e == LAT)                             ? m : '0,
                (acc && e == len + LAT)                       ? m : '0,
                (hold_ok && e == LAT + HOLD)                  ? m : '0,
                (hold_ok && e >= LAT + HOLD && e < len + LAT) ? m : '0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_in = '0;
    #12;
    check_all("reset", '0, '0, '0, '0, '0);
    tick();
    rst_n = 1'b1;

    run_press(0, 20);   // basic latency + long press
    run_press(1, 3);    // bounce shorter than DEB: no change
    run_press(2, 20);   // hold pulse, held until fall
    run_press(3, 8);    // released before HOLD: no hold
    run_press(3, 4);    // exactly DEB samples: accepted
    run_press(1, 10);   // released on the firing edge: no hold
    run_press(2, 11);   // hold fires, held lasts one cycle

    // All channels together, then reset mid-hold
    btn_in = '1;
    for (int e = 0; e < LAT + HOLD + 3; e++) begin
      tick();
      check_all($sformatf("all e%0d", e),
                (e >= LAT)              ? '1 : '0,
                (e == LAT)              ? '1 : '0,
                '0,
                (e == LAT + HOLD)       ? '1 : '0,
                (e >= LAT + HOLD)       ? '1 : '0);
    end
    rst_n = 1'b0;
    #1;
    check_all("async reset", '0, '0, '0, '0, '0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < LAT + 2; e++) begin
      tick();
      check_all($sformatf("post-reset e%0d", e),
                (e >= LAT) ? '1 : '0,
                (e == LAT) ? '1 : '0,
                '0, '0, '0);
    end
    btn_in = '0;
    for (int e = 0; e < LAT + 2; e++) tick();
    check_all("final idle", '0, '0, '0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_multi_debounce
